// File: rtl/tpm_locality_arbiter.sv
// TPM locality arbiter.
// Tracks which locality (0..NUM_LOC-1) owns the TPM interface using the
// TPM_ACCESS register model: requestUse, relinquish (activeLocality),
// Seize and beenSeized. A relinquish while a command is executing is
// parked in DRAIN until the command buffer reports idle.
module tpm_locality_arbiter #(
    parameter int NUM_LOC  = 5,
    parameter int SEIZE_EN = 1
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       acc_wr_i,
    input  logic [2:0] acc_loc_i,
    input  logic [7:0] acc_data_i,
    input  logic [2:0] acc_rdLoc_i,
    output logic [7:0] acc_rdByte_o,
    input  logic       establishment_i,
    input  logic       busy_i,
    output logic [7:0] locality_o,
    output logic       locValid_o,
    output logic       locChange_o,
    output logic       abort_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Locality indices are 3 bits; widen the limit by one bit so NUM_LOC = 8 still compares cleanly.
    localparam logic [3:0] LOC_LIMIT = 4'(NUM_LOC);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_act, w_act_nxt;
    // Per-locality flags are kept 8 wide; bits at or above NUM_LOC can never be written.
    logic [7:0] r_req, w_req_nxt;
    logic [7:0] r_seized, w_seized_nxt;
    logic       r_loc_change, w_loc_change_nxt;
    logic       r_abort, w_abort_nxt;

    logic       w_wr_ok;
    logic       w_is_active;
    logic       w_seize_ok;
    logic       w_grant;
    logic [2:0] w_winner;
    logic [7:0] w_rd_other;
    logic       w_unused_data;

    assign w_wr_ok     = acc_wr_i && ({1'b0, acc_loc_i} < LOC_LIMIT);
    assign w_is_active = (r_state != ST_IDLE) && (acc_loc_i == r_act);
    assign w_seize_ok  = (SEIZE_EN != 0) && w_wr_ok && acc_data_i[3]
                         && (r_state != ST_IDLE) && (acc_loc_i > r_act);
    assign w_grant     = (r_state == ST_IDLE) && (r_req != 8'h00);
    // Bits 7, 6, 2 and 0 of a TPM_ACCESS write carry no meaning here.
    assign w_unused_data = ^{acc_data_i[7:6], acc_data_i[2], acc_data_i[0]};

    // Highest-indexed pending requester wins a grant.
    always_comb begin
        w_winner = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (r_req[j]) w_winner = 3'(j);
        end
    end

    // Next-state logic: write decode against the pre-edge state, grant and drain exit.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        w_state_nxt      = r_state;
        w_act_nxt        = r_act;
        w_req_nxt        = r_req;
        w_seized_nxt     = r_seized;
        w_loc_change_nxt = 1'b0;
        w_abort_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt      = ST_ACTIVE;
                    w_act_nxt        = w_winner;
                    w_loc_change_nxt = 1'b1;
                end
            end
            ST_ACTIVE: ;
            ST_DRAIN: begin
                if (!busy_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_loc_change_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_wr_ok) begin
            // Clearing beenSeized is independent of every other field.
            if (acc_data_i[4]) w_seized_nxt[acc_loc_i] = 1'b0;

            if (w_seize_ok) begin
                // Seize overrides a pending drain exit and any requestUse in the same byte.
                w_seized_nxt[r_act]   = 1'b1;
                w_act_nxt             = acc_loc_i;
                w_req_nxt[acc_loc_i]  = 1'b0;
                w_state_nxt           = ST_ACTIVE;
                w_loc_change_nxt      = 1'b1;
                w_abort_nxt           = busy_i;
            end else if (acc_data_i[5]) begin
                if (w_is_active) begin
                    w_state_nxt      = busy_i ? ST_DRAIN : ST_IDLE;
                    w_loc_change_nxt = !busy_i;
                end else begin
                    w_req_nxt[acc_loc_i] = 1'b0;
                end
            end else if (acc_data_i[1] && !w_is_active) begin
                w_req_nxt[acc_loc_i] = 1'b1;
            end
        end

        // The granted locality's request is consumed by the grant itself.
        if (w_grant) w_req_nxt[w_winner] = 1'b0;
    end

    // State register; reset drops every request, seize flag and pulse.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_act        <= 3'd0;
            r_req        <= 8'h00;
            r_seized     <= 8'h00;
            r_loc_change <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            r_state      <= w_state_nxt;
            r_act        <= w_act_nxt;
            r_req        <= w_req_nxt;
            r_seized     <= w_seized_nxt;
            r_loc_change <= w_loc_change_nxt;
            r_abort      <= w_abort_nxt;
        end
    end

    assign locality_o  = (r_state == ST_IDLE) ? 8'hFF : {5'd0, r_act};
    assign locValid_o  = (r_state != ST_IDLE);
    assign locChange_o = r_loc_change;
    assign abort_o     = r_abort;

    // TPM_ACCESS read image for the addressed locality.
    always_comb begin
        w_rd_other = r_req & ~(8'd1 << acc_rdLoc_i);
        if ({1'b0, acc_rdLoc_i} >= LOC_LIMIT) begin
            acc_rdByte_o = 8'hFF;
        end else begin
            acc_rdByte_o = {1'b1,
                            1'b0,
                            locValid_o && (r_act == acc_rdLoc_i),
                            r_seized[acc_rdLoc_i],
                            1'b0,
                            |w_rd_other,
                            r_req[acc_rdLoc_i],
                            establishment_i};
        end
    end

endmodule

// File: tb/tb_tpm_locality_arbiter.sv
// Bench for tpm_locality_arbiter. Two instances share one stimulus stream:
// index 0 honours Seize, index 1 ignores it. A per-instance ownership model
// (owner index or -1, drain flag, request/seize bit sets) predicts every
// output each cycle; directed literal checks pin the model to known values.
module tb_tpm_locality_arbiter;

    localparam int NUM_LOC = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       acc_wr = 1'b0;
    logic [2:0] acc_loc = 3'd0;
    logic [7:0] acc_data = 8'h00;
    logic [2:0] rd_loc = 3'd0;
    logic       est = 1'b0;
    logic       busy = 1'b0;

    logic [7:0] o_rd [2];
    logic [7:0] o_loc [2];
    logic       o_valid [2];
    logic       o_chg [2];
    logic       o_abort [2];

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state per instance.
    int       m_owner [2];
    bit       m_drain [2];
    bit [7:0] m_req [2];
    bit [7:0] m_seized [2];
    bit       m_chg [2];
    bit       m_abort [2];

    always #5 clk = ~clk;

    tpm_locality_arbiter #(.NUM_LOC(NUM_LOC), .SEIZE_EN(1)) u_dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .acc_wr_i(acc_wr), .acc_loc_i(acc_loc), .acc_data_i(acc_data),
        .acc_rdLoc_i(rd_loc), .acc_rdByte_o(o_rd[0]),
        .establishment_i(est), .busy_i(busy),
        .locality_o(o_loc[0]), .locValid_o(o_valid[0]),
        .locChange_o(o_chg[0]), .abort_o(o_abort[0])
    );

    tpm_locality_arbiter #(.NUM_LOC(NUM_LOC), .SEIZE_EN(0)) u_noseize (
        .clock_i(clk), .reset_n_i(rst_n),
        .acc_wr_i(acc_wr), .acc_loc_i(acc_loc), .acc_data_i(acc_data),
        .acc_rdLoc_i(rd_loc), .acc_rdByte_o(o_rd[1]),
        .establishment_i(est), .busy_i(busy),
        .locality_o(o_loc[1]), .locValid_o(o_valid[1]),
        .locChange_o(o_chg[1]), .abort_o(o_abort[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k]  = -1;
            m_drain[k]  = 1'b0;
            m_req[k]    = 8'h00;
            m_seized[k] = 8'h00;
            m_chg[k]    = 1'b0;
            m_abort[k]  = 1'b0;
        end
    endtask

    // One clock edge of the ownership rules, using pre-edge inputs and state.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int       o;
            bit       dr;
            bit [7:0] pre;
            bit       seize;
            int       lw;
            int       win;
            o     = m_owner[k];
            dr    = m_drain[k];
            pre   = m_req[k];
            seize = 1'b0;
            m_chg[k]   = 1'b0;
            m_abort[k] = 1'b0;
            if (acc_wr && int'(acc_loc) < NUM_LOC) begin
                lw = int'(acc_loc);
                if (acc_data[4]) m_seized[k][lw] = 1'b0;
                seize = (k == 0) && acc_data[3] && (o >= 0) && (lw > o);
                if (seize) begin
                    m_seized[k][o] = 1'b1;
                    m_owner[k]     = lw;
                    m_drain[k]     = 1'b0;
                    m_req[k][lw]   = 1'b0;
                    m_chg[k]       = 1'b1;
                    m_abort[k]     = busy;
                end else if (acc_data[5]) begin
                    if (o == lw) begin
                        if (busy) m_drain[k] = 1'b1;
                        else begin
                            m_owner[k] = -1;
                            m_drain[k] = 1'b0;
                            m_chg[k]   = 1'b1;
                        end
                    end else begin
                        m_req[k][lw] = 1'b0;
                    end
                end else if (acc_data[1] && o != lw) begin
                    m_req[k][lw] = 1'b1;
                end
            end
            if (!seize) begin
                if (o < 0 && pre != 8'h00) begin
                    win = 0;
                    for (int j = 0; j < 8; j++) if (pre[j]) win = j;
                    m_owner[k]     = win;
                    m_req[k][win]  = 1'b0;
                    m_chg[k]       = 1'b1;
                end else if (dr && !busy && m_owner[k] >= 0) begin
                    m_owner[k] = -1;
                    m_drain[k] = 1'b0;
                    m_chg[k]   = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_rd(input int k, input logic [2:0] r);
        bit others;
        if (int'(r) >= NUM_LOC) return 8'hFF;
        others = 1'b0;
        for (int j = 0; j < NUM_LOC; j++) if (j != int'(r) && m_req[k][j]) others = 1'b1;
        return {1'b1, 1'b0, (m_owner[k] == int'(r)), m_seized[k][r], 1'b0,
                others, m_req[k][r], est};
    endfunction

    // Model advances on each edge or on asynchronous reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare all outputs of both instances against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("cyc%0d locality", k), o_loc[k],
                          (m_owner[k] < 0) ? 8'hFF : 8'(m_owner[k]));
                    check($sformatf("cyc%0d locValid", k), o_valid[k], m_owner[k] >= 0);
                    check($sformatf("cyc%0d locChange", k), o_chg[k], m_chg[k]);
                    check($sformatf("cyc%0d abort", k), o_abort[k], m_abort[k]);
                    check($sformatf("cyc%0d rdByte", k), o_rd[k], exp_rd(k, rd_loc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] loc, input logic [7:0] data);
        acc_wr   = 1'b1;
        acc_loc  = loc;
        acc_data = data;
        tick();
        acc_wr   = 1'b0;
        acc_data = 8'h00;
    endtask

    task automatic rd_check(input string name, input int k, input logic [2:0] loc, input logic [7:0] exp);
        rd_loc = loc;
        #1;
        check(name, o_rd[k], exp);
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        check("reset locality", o_loc[0], 8'hFF);
        check("reset valid", o_valid[0], 1'b0);
        check("reset change", o_chg[0], 1'b0);
        check("reset abort", o_abort[0], 1'b0);
        rd_check("reset rd0", 0, 3'd0, 8'h80);

        // Single request
        wr(3'd2, 8'h02);
        rd_check("req rd2 pending", 0, 3'd2, 8'h82);
        check("req still idle", o_loc[0], 8'hFF);
        tick();
        check("grant locality", o_loc[0], 8'h02);
        check("grant change", o_chg[0], 1'b1);
        rd_check("grant rd2", 0, 3'd2, 8'hA0);
        rd_check("grant rd0", 0, 3'd0, 8'h80);

        // Relinquish with requestUse in the same byte: request ignored
        wr(3'd2, 8'h22);
        check("relq22 locality", o_loc[0], 8'hFF);
        check("relq22 change", o_chg[0], 1'b1);
        rd_check("relq22 rd2", 0, 3'd2, 8'h80);
        tick();
        check("relq22 stays idle", o_loc[0], 8'hFF);

        // Contention
        wr(3'd0, 8'h02);
        tick();
        check("cont loc0", o_loc[0], 8'h00);
        wr(3'd1, 8'h02);
        wr(3'd3, 8'h02);
        wr(3'd0, 8'h20);
        check("cont gap", o_loc[0], 8'hFF);
        tick();
        check("cont winner", o_loc[0], 8'h03);
        rd_check("cont rd3", 0, 3'd3, 8'hA4);

        // Drain
        wr(3'd3, 8'h20);
        check("drain pre idle", o_loc[0], 8'hFF);
        tick();
        check("drain loc1", o_loc[0], 8'h01);
        busy = 1'b1;
        wr(3'd1, 8'h20);
        check("drain held", o_loc[0], 8'h01);
        check("drain no change", o_chg[0], 1'b0);
        tick();
        tick();
        check("drain held2", o_loc[0], 8'h01);
        busy = 1'b0;
        tick();
        check("drain exit", o_loc[0], 8'hFF);
        check("drain exit change", o_chg[0], 1'b1);

        // Seize while busy
        wr(3'd0, 8'h02);
        tick();
        check("seize pre loc0", o_loc[0], 8'h00);
        busy = 1'b1;
        wr(3'd4, 8'h08);
        check("seize locality", o_loc[0], 8'h04);
        check("seize change", o_chg[0], 1'b1);
        check("seize abort", o_abort[0], 1'b1);
        check("noseize locality", o_loc[1], 8'h00);
        check("noseize abort", o_abort[1], 1'b0);
        rd_check("seize rd0", 0, 3'd0, 8'h90);
        rd_check("noseize rd0", 1, 3'd0, 8'hA0);
        wr(3'd0, 8'h10);
        rd_check("seize cleared rd0", 0, 3'd0, 8'h80);
        check("abort one cycle", o_abort[0], 1'b0);
        busy = 1'b0;

        // Illegal writes
        wr(3'd4, 8'h20);
        wr(3'd3, 8'h02);
        tick();
        check("illegal pre loc3", o_loc[0], 8'h03);
        wr(3'd1, 8'h08);
        check("low seize ignored", o_loc[0], 8'h03);
        check("low seize no abort", o_abort[0], 1'b0);
        check("low seize no change", o_chg[0], 1'b0);
        wr(3'd6, 8'h02);
        check("loc6 ignored", o_loc[0], 8'h03);
        rd_check("rd6", 0, 3'd6, 8'hFF);
        rd_check("rd3 after illegal", 0, 3'd3, 8'hA0);

        // Seize without busy, and the disabled instance ignoring it
        wr(3'd4, 8'h08);
        check("idle-busy seize loc", o_loc[0], 8'h04);
        check("idle-busy seize no abort", o_abort[0], 1'b0);
        check("noseize loc kept", o_loc[1], 8'h00);
        check("noseize no change", o_chg[1], 1'b0);
        rd_check("seized rd3", 0, 3'd3, 8'h90);
        rd_check("noseize rd3", 1, 3'd3, 8'h82);

        // Reset mid-DRAIN
        busy = 1'b1;
        wr(3'd4, 8'h20);
        check("pre-reset drain", o_loc[0], 8'h04);
        est = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst%0d locality", k), o_loc[k], 8'hFF);
            check($sformatf("rst%0d valid", k), o_valid[k], 1'b0);
            check($sformatf("rst%0d change", k), o_chg[k], 1'b0);
            check($sformatf("rst%0d abort", k), o_abort[k], 1'b0);
        end
        for (int r = 0; r < 8; r++) begin
            rd_loc = 3'(r);
            #1;
            check($sformatf("rst rd%0d", r), o_rd[0], (r < NUM_LOC) ? 8'h81 : 8'hFF);
            check($sformatf("rst ns rd%0d", r), o_rd[1], (r < NUM_LOC) ? 8'h81 : 8'hFF);
        end
        busy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr(3'd2, 8'h02);
        tick();
        check("post-reset grant", o_loc[0], 8'h02);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpm_locality_arbiter.md
Name: tpm_locality_arbiter

Overview:
Arbitrates ownership of the TPM interface among localities 0-4 using TPM_ACCESS register semantics: requestUse, activeLocality relinquish, Seize, beenSeized and pendingRequest. It sits between the FIFO/CRB register space, which forwards TPM_ACCESS writes and reads, and the command/response buffer, which consumes the active locality and an abort pulse. Relinquish is held off while a command is executing.

Parameters:
NUM_LOC, 5, number of implemented localities (1-8)
SEIZE_EN, 1, 1 = Seize honoured; 0 = Seize writes ignored

Ports:
clock_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
acc_wr_i  in  1  one-cycle strobe: TPM_ACCESS write
acc_loc_i  in  3  locality targeted by the write
acc_data_i  in  8  write data (bit5 relinquish, bit4 clear beenSeized, bit3 seize, bit1 requestUse)
acc_rdLoc_i  in  3  locality whose TPM_ACCESS is read
acc_rdByte_o  out  8  TPM_ACCESS read value (combinational)
establishment_i  in  1  tpmEstablishment status bit
busy_i  in  1  CRB command executing
locality_o  out  8  active locality index; 8'hFF = none
locValid_o  out  1  a locality is active
locChange_o  out  1  one-cycle pulse when locality_o changes
abort_o  out  1  one-cycle pulse: seize occurred while busy_i=1

Behaviour:
- Reset (asynchronous):
  - State = IDLE; locality_o = 8'hFF; locValid_o = 0.
  - requestUse[] = 0; beenSeized[] = 0; locChange_o = 0; abort_o = 0.
- State machine: IDLE, ACTIVE, DRAIN. The active index is registered in act.
- Write decode: sampled on the edge where acc_wr_i = 1, evaluated against the pre-edge state.
  - acc_loc_i >= NUM_LOC: write ignored.
  - Bit4 = 1: clear beenSeized[L]. Always legal, independent of the other bits.
  - Bit3 (seize): honoured only if all of the following hold; otherwise ignored.
    - SEIZE_EN = 1
    - state is ACTIVE or DRAIN
    - L > act
  - Seize effect on that edge:
    - beenSeized[act] = 1; act = L; requestUse[L] = 0; state = ACTIVE.
    - locChange_o = 1; abort_o = 1 if busy_i = 1.
    - bit1 in the same byte is ignored.
  - Bit5 from the active locality:
    - busy_i = 0: go to IDLE (locality_o = 8'hFF, locChange_o).
    - busy_i = 1: go to DRAIN.
  - Bit5 from a non-active locality: clears requestUse[L], cancelling a pending request.
  - Bit1 from a non-active locality sets requestUse[L]. From the active locality it is ignored.
  - If bits 5 and 1 are both set: relinquish is processed and bit1 is ignored.
- Grant: in IDLE with any requestUse set, the highest-indexed requester wins.
  - act = winner; its requestUse bit is cleared; state = ACTIVE; locChange_o = 1.
  - Latency: requestUse is set after write edge k; locality_o is valid after edge k+1.
- DRAIN:
  - locality_o and locValid_o are held.
  - requestUse writes are still accepted; seize is still accepted (see Seize).
  - On the first edge with busy_i = 0: go to IDLE with locChange_o = 1.
- Every release passes through IDLE, so locality_o = 8'hFF for at least one cycle before the next grant.
- Read byte for R = acc_rdLoc_i:
  - R >= NUM_LOC: 8'hFF.
  - Otherwise the fields are:
    - bit7 = 1
    - bit6 = 0
    - bit5 = (locValid_o && act == R)
    - bit4 = beenSeized[R]
    - bit3 = 0
    - bit2 = OR of requestUse[j] for j != R
    - bit1 = requestUse[R]
    - bit0 = establishment_i
- Pulses: locChange_o and abort_o last exactly one cycle and are never asserted in the same cycle as reset.
- locality_o is zero-extended from act.
- Reset mid-DRAIN or mid-request: all state is lost; no pulses are emitted.

Test Plan:
- Single request:
  - Stimulus: reset, then write loc 2 data 8'h02.
  - Response: read loc 2 = 8'h82 after 1 edge; next edge locality_o = 8'h02, locChange_o pulse; read loc 2 = 8'hA0; read loc 0 = 8'h80.
- Contention:
  - Stimulus: loc 0 active; loc 1 and loc 3 write 8'h02; loc 0 writes 8'h20 with busy_i = 0.
  - Response: locality_o = 8'hFF for 1 cycle, then 8'h03; read loc 3 bit2 = 1 (loc 1 pending).
- Drain:
  - Stimulus: loc 1 active, busy_i = 1, loc 1 writes 8'h20.
  - Response: locality_o stays 8'h01 while busy; 1 edge after busy_i falls, locality_o = 8'hFF with locChange_o.
- Seize:
  - Stimulus: loc 0 active, busy_i = 1, loc 4 writes 8'h08.
  - Response: locality_o = 8'h04; abort_o and locChange_o pulse together; read loc 0 = 8'h90; loc 0 writes 8'h10, then read loc 0 = 8'h80.
- Illegal writes:
  - Stimulus: loc 3 active; loc 1 writes seize; loc 6 writes 8'h02.
  - Response: no state change; read loc 6 = 8'hFF.
  - Rerun with SEIZE_EN = 0: loc 4 seize is also ignored.
- Reset mid-DRAIN:
  - Stimulus: assert reset_n_i low asynchronously while in DRAIN.
  - Response: locality_o = 8'hFF and all read bytes = 8'h80 | establishment_i immediately.
